// File: rtl/signal_conflict_monitor.sv
// Fail-safe monitor for a two-approach lamp interface: registers the lamp drives, checks them for
// conflicts, bad patterns, illegal sequences and short yellows, and latches the first fault.
module signal_conflict_monitor #(
  parameter int unsigned YMIN      = 3,
  parameter int unsigned GLITCH    = 1,
  parameter int unsigned FLASH_DIV = 4
) (
  input  logic       CK,
  input  logic       CLR,
  input  logic       GRN1,
  input  logic       YLW1,
  input  logic       RED1,
  input  logic       GRN2,
  input  logic       YLW2,
  input  logic       RED2,
  input  logic       ACK,
  output logic       FAULT,
  output logic [2:0] FCODE,
  output logic       FLASH
);

  typedef enum logic [1:0] {StUnk, StGrn, StYlw, StRed} aspect_e;

  localparam int unsigned   DivW      = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam logic [DivW-1:0] DivMax  = DivW'(FLASH_DIV - 1);
  localparam logic [2:0]    GlitchLim = 3'(GLITCH);
  localparam logic [3:0]    YminLim   = 4'(YMIN);

  logic [5:0]      lamp_q;  // {G1, Y1, R1, G2, Y2, R2}
  aspect_e         st_q [2];
  aspect_e         st_d [2];
  aspect_e         asp  [2];
  logic [3:0]      ycnt_q [2];
  logic [3:0]      ycnt_d [2];
  logic [2:0]      gl_q [2];
  logic [2:0]      gl_d [2];
  logic            lg [2];
  logic            ly [2];
  logic            lr [2];
  logic            seq_flt [2];
  logic            short_flt [2];
  logic            lamp_flt [2];
  logic            conflict;
  logic [2:0]      code;
  logic            viol;
  logic            fault_q, fault_d;
  logic [2:0]      code_q, code_d;
  logic            flash_q, flash_d;
  logic [DivW-1:0] div_q, div_d;

  assign lg[0] = lamp_q[5];
  assign ly[0] = lamp_q[4];
  assign lr[0] = lamp_q[3];
  assign lg[1] = lamp_q[2];
  assign ly[1] = lamp_q[1];
  assign lr[1] = lamp_q[0];

  assign conflict = (lg[0] | ly[0]) & (lg[1] | ly[1]);

  always_comb begin
    for (int a = 0; a < 2; a++) begin
      st_d[a]      = st_q[a];
      ycnt_d[a]    = ycnt_q[a];
      gl_d[a]      = gl_q[a];
      asp[a]       = StUnk;
      seq_flt[a]   = 1'b0;
      short_flt[a] = 1'b0;
      if ($onehot({lg[a], ly[a], lr[a]})) begin
        if (lg[a])      asp[a] = StGrn;
        else if (ly[a]) asp[a] = StYlw;
        else            asp[a] = StRed;
        st_d[a] = asp[a];
        gl_d[a] = 3'd0;
        seq_flt[a] = (st_q[a] == StGrn && asp[a] == StRed) ||
                     (st_q[a] == StYlw && asp[a] == StGrn) ||
                     (st_q[a] == StRed && asp[a] == StYlw);
        short_flt[a] = (st_q[a] == StYlw) && (asp[a] == StRed) && (ycnt_q[a] < YminLim);
        // The entry cycle counts as the first yellow cycle.
        if (asp[a] == StYlw) begin
          if (st_q[a] != StYlw)         ycnt_d[a] = 4'd1;
          else if (ycnt_q[a] != 4'd15)  ycnt_d[a] = ycnt_q[a] + 4'd1;
        end else begin
          ycnt_d[a] = 4'd0;
        end
      end else if (gl_q[a] != 3'd7) begin
        gl_d[a] = gl_q[a] + 3'd1;
      end
      lamp_flt[a] = gl_d[a] > GlitchLim;
    end

    if (conflict)          code = 3'd1;
    else if (lamp_flt[0])  code = 3'd2;
    else if (lamp_flt[1])  code = 3'd3;
    else if (seq_flt[0])   code = 3'd4;
    else if (seq_flt[1])   code = 3'd5;
    else if (short_flt[0]) code = 3'd6;
    else if (short_flt[1]) code = 3'd7;
    else                   code = 3'd0;
    viol = (code != 3'd0);

    fault_d = fault_q;
    code_d  = code_q;
    flash_d = flash_q;
    div_d   = div_q;
    if (fault_q && ACK && !viol) begin
      // Re-arm: the first aspect afterwards is accepted without a sequence check.
      fault_d = 1'b0;
      code_d  = 3'd0;
      flash_d = 1'b0;
      div_d   = '0;
      for (int a = 0; a < 2; a++) begin
        st_d[a]   = StUnk;
        ycnt_d[a] = 4'd0;
        gl_d[a]   = 3'd0;
      end
    end else if (!fault_q && viol) begin
      fault_d = 1'b1;
      code_d  = code;
      flash_d = 1'b1;
      div_d   = '0;
    end else if (fault_q) begin
      if (div_q == DivMax) begin
        flash_d = ~flash_q;
        div_d   = '0;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CK or posedge CLR) begin
    if (CLR) begin
      lamp_q  <= '0;
      fault_q <= 1'b0;
      code_q  <= 3'd0;
      flash_q <= 1'b0;
      div_q   <= '0;
      for (int a = 0; a < 2; a++) begin
        st_q[a]   <= StUnk;
        ycnt_q[a] <= 4'd0;
        gl_q[a]   <= 3'd0;
      end
    end else begin
      lamp_q  <= {GRN1, YLW1, RED1, GRN2, YLW2, RED2};
      fault_q <= fault_d;
      code_q  <= code_d;
      flash_q <= flash_d;
      div_q   <= div_d;
      for (int a = 0; a < 2; a++) begin
        st_q[a]   <= st_d[a];
        ycnt_q[a] <= ycnt_d[a];
        gl_q[a]   <= gl_d[a];
      end
    end
  end

  assign FAULT = fault_q;
  assign FCODE = code_q;
  assign FLASH = flash_q;

endmodule

// File: tb/tb_signal_conflict_monitor.sv
// Directed self-checking bench for signal_conflict_monitor (YMIN=3, GLITCH=1, FLASH_DIV=4).
module tb_signal_conflict_monitor;

  logic       CK = 1'b0;
  logic       CLR = 1'b1;
  logic       GRN1 = 0, YLW1 = 0, RED1 = 0, GRN2 = 0, YLW2 = 0, RED2 = 0;
  logic       ACK = 1'b0;
  logic       FAULT;
  logic [2:0] FCODE;
  logic       FLASH;

  int total = 0;
  int bad   = 0;

  // Lamp words {G1, Y1, R1, G2, Y2, R2}
  localparam logic [5:0] R1G2 = 6'b001_100;
  localparam logic [5:0] R1Y2 = 6'b001_010;
  localparam logic [5:0] RR   = 6'b001_001;
  localparam logic [5:0] G1R2 = 6'b100_001;
  localparam logic [5:0] Y1R2 = 6'b010_001;
  localparam logic [5:0] G1Y2 = 6'b100_010;

  signal_conflict_monitor #(.YMIN(3), .GLITCH(1), .FLASH_DIV(4)) dut (
    .CK(CK), .CLR(CLR),
    .GRN1(GRN1), .YLW1(YLW1), .RED1(RED1),
    .GRN2(GRN2), .YLW2(YLW2), .RED2(RED2),
    .ACK(ACK), .FAULT(FAULT), .FCODE(FCODE), .FLASH(FLASH)
  );

  always #5 CK = ~CK;

  task automatic drive(input logic [5:0] l);
    {GRN1, YLW1, RED1, GRN2, YLW2, RED2} = l;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CK);
      #1;
    end
  endtask

  task automatic do_reset();
    ACK = 1'b0;
    CLR = 1'b1;
    #2;
    CLR = 1'b0;
  endtask

  task automatic test_reset();
    step(1);
    do_reset();
    total++; if (FAULT !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b exp=0", FAULT); end
    total++; if (FCODE !== 3'd0) begin bad++; $display("FAIL reset_fcode got=%0d exp=0", FCODE); end
    total++; if (FLASH !== 1'b0) begin bad++; $display("FAIL reset_flash got=%b exp=0", FLASH); end
  endtask

  task automatic test_legal();
    logic [5:0] seq [13];
    seq = '{R1G2, R1G2, R1Y2, R1Y2, R1Y2, R1Y2, RR, G1R2, G1R2, Y1R2, Y1R2, Y1R2, RR};
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 13; i++) begin
        drive(seq[i]);
        step(1);
        total++;
        if (FAULT !== 1'b0 || FCODE !== 3'd0 || FLASH !== 1'b0) begin
          bad++;
          $display("FAIL legal rep%0d idx%0d got=%b/%0d/%b exp=0/0/0", rep, i, FAULT, FCODE, FLASH);
        end
      end
    end
    step(2);
    total++; if (FAULT !== 1'b0) begin bad++; $display("FAIL legal_tail got=%b exp=0", FAULT); end
  endtask

  task automatic test_conflict_flash();
    logic [7:0] exp_flash;
    exp_flash = 8'b1111_0000;
    do_reset();
    drive(RR); step(2);
    drive(G1Y2); step(1);
    total++; if (FAULT !== 1'b0) begin bad++; $display("FAIL conf_latency got=%b exp=0", FAULT); end
    drive(RR); step(1);
    total++; if (FAULT !== 1'b1 || FCODE !== 3'd1) begin
      bad++; $display("FAIL conf_code got=%b/%0d exp=1/1", FAULT, FCODE); end
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step(1);
      total++; if (FLASH !== exp_flash[7-i]) begin
        bad++; $display("FAIL flash_seq i%0d got=%b exp=%b", i, FLASH, exp_flash[7-i]); end
    end
    step(1);
    total++; if (FLASH !== 1'b1) begin bad++; $display("FAIL flash_wrap got=%b exp=1", FLASH); end
    total++; if (FCODE !== 3'd1) begin bad++; $display("FAIL conf_hold got=%0d exp=1", FCODE); end
  endtask

  task automatic test_sequence();
    do_reset();
    drive(G1R2); step(2);
    drive(RR); step(1);
    total++; if (FAULT !== 1'b0) begin bad++; $display("FAIL seq1_early got=%b exp=0", FAULT); end
    step(1);
    total++; if (FAULT !== 1'b1 || FCODE !== 3'd4) begin
      bad++; $display("FAIL seq1_code got=%b/%0d exp=1/4", FAULT, FCODE); end
  endtask

  task automatic test_short_yellow();
    do_reset();
    drive(R1G2); step(2);
    drive(R1Y2); step(2);
    drive(RR); step(1);
    total++; if (FAULT !== 1'b0) begin bad++; $display("FAIL sy_early got=%b exp=0", FAULT); end
    step(1);
    total++; if (FAULT !== 1'b1 || FCODE !== 3'd7) begin
      bad++; $display("FAIL sy_code got=%b/%0d exp=1/7", FAULT, FCODE); end
  endtask

  task automatic test_glitch();
    do_reset();
    drive(RR); step(2);
    drive(6'b000_001); step(1);
    drive(RR);
    for (int i = 0; i < 3; i++) begin
      step(1);
      total++; if (FAULT !== 1'b0) begin bad++; $display("FAIL glitch1 i%0d got=%b exp=0", i, FAULT); end
    end
    drive(6'b000_001); step(2);
    drive(RR);
    total++; if (FAULT !== 1'b0) begin bad++; $display("FAIL glitch2_early got=%b exp=0", FAULT); end
    step(1);
    total++; if (FAULT !== 1'b1 || FCODE !== 3'd2) begin
      bad++; $display("FAIL glitch2_code got=%b/%0d exp=1/2", FAULT, FCODE); end
    // Second invalid cycle on approach 1 coincides with a green/green conflict.
    do_reset();
    drive(RR); step(2);
    drive(6'b000_001); step(1);
    drive(6'b101_100); step(1);
    drive(RR); step(1);
    total++; if (FAULT !== 1'b1 || FCODE !== 3'd1) begin
      bad++; $display("FAIL glitch_conf got=%b/%0d exp=1/1", FAULT, FCODE); end
  endtask

  task automatic test_ack();
    do_reset();
    drive(R1G2); step(2);
    drive(G1Y2); step(2);
    total++; if (FAULT !== 1'b1 || FCODE !== 3'd1) begin
      bad++; $display("FAIL ack_setup got=%b/%0d exp=1/1", FAULT, FCODE); end
    ACK = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      total++; if (FAULT !== 1'b1 || FCODE !== 3'd1) begin
        bad++; $display("FAIL ack_blocked i%0d got=%b/%0d exp=1/1", i, FAULT, FCODE); end
    end
    drive(G1R2); step(1);
    total++; if (FAULT !== 1'b1) begin bad++; $display("FAIL ack_pipe got=%b exp=1", FAULT); end
    drive(RR); step(1);
    ACK = 1'b0;
    total++; if (FAULT !== 1'b0 || FCODE !== 3'd0 || FLASH !== 1'b0) begin
      bad++; $display("FAIL ack_clear got=%b/%0d/%b exp=0/0/0", FAULT, FCODE, FLASH); end
    // Approach 1 was green before re-arm; red now is accepted because tracking restarted.
    step(3);
    total++; if (FAULT !== 1'b0) begin bad++; $display("FAIL ack_unk got=%b exp=0", FAULT); end
    drive(G1R2); step(3);
    total++; if (FAULT !== 1'b0) begin bad++; $display("FAIL ack_rg got=%b exp=0", FAULT); end
  endtask

  task automatic test_clr_async();
    do_reset();
    drive(RR); step(2);
    drive(G1Y2); step(3);
    total++; if (FAULT !== 1'b1) begin bad++; $display("FAIL clr_setup got=%b exp=1", FAULT); end
    #2 CLR = 1'b1;
    #1;
    total++; if (FAULT !== 1'b0 || FCODE !== 3'd0 || FLASH !== 1'b0) begin
      bad++; $display("FAIL clr_async got=%b/%0d/%b exp=0/0/0", FAULT, FCODE, FLASH); end
    CLR = 1'b0;
    drive(R1G2); step(2);
    drive(R1Y2); step(2);
    #2 CLR = 1'b1;
    #1 CLR = 1'b0;
    drive(RR); step(4);
    total++; if (FAULT !== 1'b0) begin bad++; $display("FAIL clr_midyel got=%b exp=0", FAULT); end
    drive(G1Y2); step(2);
    total++; if (FAULT !== 1'b1 || FCODE !== 3'd1) begin
      bad++; $display("FAIL clr_resume got=%b/%0d exp=1/1", FAULT, FCODE); end
  endtask

  initial begin
    test_reset();
    test_legal();
    test_conflict_flash();
    test_sequence();
    test_short_yellow();
    test_glitch();
    test_ack();
    test_clr_async();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
